// File: rtl/bcd_updown_counter_n.sv
// N-digit packed-BCD up/down counter with tick prescaler, preset loading and limit flags.
// Define BCD_WRAP_EN to wrap at the limits instead of saturating.
module bcd_updown_counter_n #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   count,
  output logic                  at_zero,
  output logic                  at_max,
  output logic                  terminal
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LO = DIGITS / 2;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    LOAD_ZERO  = 2'b00,
    LOAD_UPPER = 2'b01,
    LOAD_NINES = 2'b10,
    LOAD_FULL  = 2'b11
  } load_mode_e;

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [W-1:0]  count_inc;
  logic [W-1:0]  count_dec;
  logic [W-1:0]  load_raw;
  logic [W-1:0]  load_value;
  logic [W-1:0]  stepped;
  logic          all_nines;
  logic          all_zero;
  logic          limit_hit;

  assign tick = (prescaler == P_LAST);

  // Full ripple: a digit moves only while every lower digit carried or borrowed.
  always_comb begin
    logic carry;
    logic borrow;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    count_inc = count;
    count_dec = count;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  assign all_zero = (count == '0);
  assign at_zero  = all_zero;
  assign at_max   = all_nines;

  always_comb begin
    load_raw = '0;
    case (load_mode_e'(mode))
      LOAD_ZERO:  load_raw = '0;
      LOAD_UPPER: begin
        load_raw = preset;
        for (int i = 0; i < LO; i++) load_raw[4*i +: 4] = 4'd0;
      end
      LOAD_NINES: begin
        for (int i = 0; i < DIGITS; i++) load_raw[4*i +: 4] = 4'd9;
      end
      LOAD_FULL:  load_raw = preset;
      default:    load_raw = '0;
    endcase
  end

  // Non-decimal digits are zeroed one digit at a time.
  always_comb begin
    load_value = load_raw;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_raw[4*i +: 4] > 4'd9) load_value[4*i +: 4] = 4'd0;
    end
  end

  assign limit_hit = up ? all_nines : all_zero;

`ifdef BCD_WRAP_EN
  // The ripple already rolls 9..9 -> 0..0 and 0..0 -> 9..9.
  assign stepped = up ? count_inc : count_dec;
`else
  assign stepped = limit_hit ? count : (up ? count_inc : count_dec);
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      count     <= '0;
      prescaler <= '0;
      terminal  <= 1'b0;
    end else begin
      terminal <= 1'b0;
      if (load) begin
        count     <= load_value;
        prescaler <= '0;
      end else begin
        prescaler <= tick ? '0 : prescaler + PW'(1);
        if (tick && enable) begin
          count    <= stepped;
          terminal <= limit_hit;
        end
      end
    end
  end

endmodule
